// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate extender with a one-cycle valid/ready pipeline stage.
// A 2-entry skid buffer absorbs execute back-pressure; illegal formats are flagged and counted.
//
// state | meaning
// EMPTY | no entry held, output invalid
// ONE   | output register holds a valid entry
// FULL  | output and skid registers both valid, upstream stalled
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] out_tag,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    state_t           state, state_nxt;
    logic             in_ready_q;
    logic             in_xfer, out_xfer, accept;
    logic [XLEN-1:0]  imm_new;
    logic             ill_new;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_ill;
    logic             unused_opcode;

    assign unused_opcode = ^instr[6:0];

    always_comb begin
        imm_new = {XLEN{instr[31]}};
        ill_new = 1'b0;
        case (ImmSrc)
            3'b000: imm_new[11:0] = instr[31:20];
            3'b001: imm_new[11:0] = {instr[31:25], instr[11:7]};
            3'b010: imm_new[11:0] = {instr[7], instr[30:25], instr[11:8], 1'b0};
            3'b011: imm_new = '0;
            3'b100: imm_new[19:0] = {instr[19:12], instr[20], instr[30:21], 1'b0};
            3'b101: imm_new[31:0] = {instr[31:12], 12'h000};
            3'b110: begin
                imm_new = '0;
                if (XLEN == 64) imm_new[5:0] = instr[25:20];
                else            imm_new[4:0] = instr[24:20];
            end
            default: begin
                imm_new = '0;
                ill_new = 1'b1;
            end
        endcase
    end

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;
    assign accept   = in_xfer & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != FULL);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (in_xfer) state_nxt = ONE;
            ONE: begin
                if (out_xfer && !in_xfer)      state_nxt = EMPTY;
                else if (in_xfer && !out_xfer) state_nxt = FULL;
            end
            FULL:    if (out_xfer) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
    end

    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state != EMPTY);
    end

    // Output register reloads from the input or drains the skid; skid only fills from ONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ImmExt      <= '0;
            out_tag     <= '0;
            illegal     <= 1'b0;
            skid_imm    <= '0;
            skid_tag    <= '0;
            skid_ill    <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            if (accept && (state == EMPTY || (state == ONE && out_xfer))) begin
                ImmExt  <= imm_new;
                out_tag <= in_tag;
                illegal <= ill_new;
            end else if (!flush && state == FULL && out_xfer) begin
                ImmExt  <= skid_imm;
                out_tag <= skid_tag;
                illegal <= skid_ill;
            end
            if (accept && state == ONE && !out_xfer) begin
                skid_imm <= imm_new;
                skid_tag <= in_tag;
                skid_ill <= ill_new;
            end
            if (accept && ill_new && illegal_cnt != {CNT_W{1'b1}})
                illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  ImmSrc;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready_32, out_valid_32, illegal_32;
    logic [31:0] imm_32, tag_32;
    logic [7:0]  cnt_32;
    logic        in_ready_64, out_valid_64, illegal_64;
    logic [63:0] imm_64;
    logic [31:0] tag_64;
    logic [7:0]  cnt_64;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] cnt_before;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_32),
        .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .out_valid(out_valid_32),
        .out_ready(out_ready), .ImmExt(imm_32), .out_tag(tag_32), .illegal(illegal_32),
        .illegal_cnt(cnt_32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_64),
        .instr(instr), .ImmSrc(ImmSrc), .in_tag(in_tag), .out_valid(out_valid_64),
        .out_ready(out_ready), .ImmExt(imm_64), .out_tag(tag_64), .illegal(illegal_64),
        .illegal_cnt(cnt_64)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle with out_ready=1, check both widths, then drain.
    task automatic send(input string name, input logic [31:0] i, input logic [2:0] s,
                        input logic [31:0] t, input logic [31:0] e32, input logic [63:0] e64,
                        input logic eill);
        in_valid = 1'b1; instr = i; ImmSrc = s; in_tag = t;
        step();
        in_valid = 1'b0;
        chk({name, "_valid"}, {63'd0, out_valid_32}, 64'd1);
        chk({name, "_imm32"}, {32'd0, imm_32}, {32'd0, e32});
        chk({name, "_imm64"}, imm_64, e64);
        chk({name, "_tag"}, {32'd0, tag_32}, {32'd0, t});
        chk({name, "_ill"}, {63'd0, illegal_64}, {63'd0, eill});
        step();
        chk({name, "_drain"}, {63'd0, out_valid_64}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; ImmSrc = '0;
        in_tag = '0; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", {63'd0, in_ready_32}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid_32}, 64'd0);
        chk("rst_cnt", {56'd0, cnt_32}, 64'd0);
        chk("rst_imm", imm_64, 64'd0);
        #11 rst_n = 1'b1;
        step();
        chk("rel_in_ready", {62'd0, in_ready_32, in_ready_64}, 64'd3);

        send("I_neg", 32'hFFF00093, 3'b000, 32'd10, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send("I_pos", 32'h7FF00093, 3'b000, 32'd11, 32'h000007FF, 64'h00000000000007FF, 1'b0);
        send("S", 32'hFE112E23, 3'b001, 32'd12, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send("B", 32'hFE000EE3, 3'b010, 32'd13, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        send("R", 32'hFFFFFFFF, 3'b011, 32'd14, 32'h00000000, 64'h0, 1'b0);
        send("J", 32'h0080006F, 3'b100, 32'd15, 32'h00000008, 64'h8, 1'b0);
        send("U", 32'h800002B7, 3'b101, 32'd16, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0);
        send("SHAMT", 32'h03F00013, 3'b110, 32'd17, 32'h0000001F, 64'h3F, 1'b0);
        send("ILL", 32'hFFFFFFFF, 3'b111, 32'd18, 32'h00000000, 64'h0, 1'b1);
        chk("ill_cnt1", {56'd0, cnt_32}, 64'd1);

        // Back-pressure: tags 1,2 fill the buffer, tag 3 must wait upstream.
        out_ready = 1'b0; ImmSrc = 3'b000; instr = 32'h00100093;
        in_valid = 1'b1; in_tag = 32'd1;
        step();
        chk("bp_rdy_one", {63'd0, in_ready_32}, 64'd1);
        in_tag = 32'd2;
        step();
        chk("bp_rdy_full", {63'd0, in_ready_32}, 64'd0);
        chk("bp_tag_hold1", {32'd0, tag_32}, 64'd1);
        in_tag = 32'd3;
        step();
        chk("bp_stall_rdy", {63'd0, in_ready_64}, 64'd0);
        chk("bp_stall_tag", {32'd0, tag_64}, 64'd1);
        chk("bp_stall_val", {63'd0, out_valid_32}, 64'd1);
        out_ready = 1'b1;
        step();
        chk("bp_out2", {32'd0, tag_32}, 64'd2);
        chk("bp_rdy_back", {63'd0, in_ready_32}, 64'd1);
        step();
        in_valid = 1'b0;
        chk("bp_out3", {32'd0, tag_32}, 64'd3);
        step();
        chk("bp_empty", {63'd0, out_valid_32}, 64'd0);

        // Flush while FULL with an illegal instruction offered the same cycle.
        out_ready = 1'b0; in_valid = 1'b1; in_tag = 32'd4;
        step();
        in_tag = 32'd5;
        step();
        chk("fl_full", {63'd0, in_ready_32}, 64'd0);
        cnt_before = cnt_32;
        flush = 1'b1; ImmSrc = 3'b111; in_tag = 32'd6;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", {63'd0, out_valid_32}, 64'd0);
        chk("fl_ready", {63'd0, in_ready_32}, 64'd1);
        chk("fl_cnt", {56'd0, cnt_32}, {56'd0, cnt_before});
        chk("fl_cnt_abs", {56'd0, cnt_64}, 64'd1);

        // Flush with an in-transfer from EMPTY: nothing appears, nothing counted.
        in_valid = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_empty_val", {63'd0, out_valid_32}, 64'd0);
        chk("fl_empty_cnt", {56'd0, cnt_32}, 64'd1);

        // Saturation: 300 illegal transfers starting from a count of 1.
        out_ready = 1'b1; ImmSrc = 3'b111; in_valid = 1'b1;
        for (int k = 0; k < 300; k++) step();
        in_valid = 1'b0;
        chk("sat_cnt32", {56'd0, cnt_32}, 64'd255);
        chk("sat_cnt64", {56'd0, cnt_64}, 64'd255);
        step();

        // Asynchronous reset mid-operation while FULL.
        out_ready = 1'b0; ImmSrc = 3'b000; in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("ar_full_val", {63'd0, out_valid_32}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_val", {63'd0, out_valid_32}, 64'd0);
        chk("ar_rdy", {63'd0, in_ready_32}, 64'd0);
        chk("ar_cnt", {56'd0, cnt_32}, 64'd0);
        chk("ar_tag", {32'd0, tag_32}, 64'd0);
        #3 rst_n = 1'b1;
        step();
        chk("ar_rel_rdy", {63'd0, in_ready_32}, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, parametrised successor to the decode-stage immediate extender for the pipelined RISC-V core.
- Takes a raw instruction, an immediate-format select and a sideband tag, and produces the extended immediate one cycle later on a valid/ready interface.
- Holds data in a 2-entry skid buffer so back-pressure from execute never drops an instruction.
- Adds XLEN generalisation (32/64), a shift-amount format, an illegal-format flag, a flush, and a saturating illegal-format counter.

Parameters:
- XLEN, 32, immediate output width; legal values are 32 or 64.
- TAG_W, 32, width of the sideband tag (PC/ROB id), passed through unchanged.
- CNT_W, 8, width of the saturating illegal-format counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline flush.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  block can accept this cycle.
- instr  in  32  raw instruction word.
- ImmSrc  in  3  immediate format select.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  ImmExt/out_tag/illegal are valid.
- out_ready  in  1  downstream accepts.
- ImmExt  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag matching ImmExt.
- illegal  out  1  ImmSrc was 3'b111.
- illegal_cnt  out  CNT_W  saturating count of accepted illegal formats.

Behaviour:
- Extension rules, with s = instr[31] replicated up to XLEN:
  - 000 I: s, instr[31:20].
  - 001 S: s, instr[31:25], instr[11:7].
  - 010 B: s, instr[7], instr[30:25], instr[11:8], 0.
  - 011 R: zero.
  - 100 J: s, instr[19:12], instr[20], instr[30:21], 0.
  - 101 U: s, instr[31:12], 12'b0 (sign-extended when XLEN=64).
  - 110 SHAMT: zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - 111: zero, with illegal=1.
- Transfers: in-transfer is in_valid & in_ready; out-transfer is out_valid & out_ready.
- Latency: exactly 1 cycle from in-transfer to out_valid when the buffer is empty.
- State machine (3 states):
  - EMPTY: in_ready=1, out_valid=0. An in-transfer loads the output register and moves to ONE.
  - ONE: in_ready=1, out_valid=1.
    - Out-transfer with in-transfer: reload the output register, stay in ONE.
    - Out-transfer only: go to EMPTY.
    - In-transfer only: load the skid register, go to FULL.
  - FULL: in_ready=0, out_valid=1. An out-transfer moves skid to output, go to ONE.
- in_ready is a registered function of state only; there is no combinational path from out_ready to in_ready.
- Outputs hold stable while out_valid=1 and out_ready=0.
- flush: next state is EMPTY and both entries are invalidated regardless of in/out activity that cycle. A same-cycle in-transfer is discarded and is not counted.
- illegal_cnt:
  - Increments by 1 on each in-transfer with ImmSrc=111 that is not flushed.
  - Saturates at all-ones.
  - Flush does not clear it.
- Reset (asynchronous, active-low) forces:
  - state EMPTY, out_valid=0.
  - ImmExt=0, out_tag=0, illegal=0, illegal_cnt=0.
  - in_ready=0 while rst_n=0, then 1 from the first clock edge after deassertion.
- Reset asserted mid-operation drops all buffered entries immediately, without waiting for a clock edge.

Test Plan:
- Reset sequence → out_valid=0, illegal_cnt=0, in_ready=1 after release.
- instr=32'hFFF00093, ImmSrc=000, out_ready=1, XLEN=32 → one cycle later ImmExt=32'hFFFFFFFF.
- instr=32'hFE000EE3 (B-type, offset -4), ImmSrc=010 → ImmExt=32'hFFFFFFFC.
- instr=32'h800002B7, ImmSrc=101, XLEN=64 → ImmExt=64'hFFFFFFFF80000000.
- Back-pressure: out_ready=0 while 3 back-to-back valid inputs with tags 1,2,3 are presented → tags 1,2 accepted, in_ready=0 from cycle 2, tag 3 held upstream. Then out_ready=1 → outputs tags 1,2,3 in order with no loss or duplication.
- Flush in FULL with in_valid=1 → next cycle out_valid=0, in_ready=1, illegal_cnt unchanged. Separately, 300 illegal inputs with CNT_W=8 → illegal_cnt=255.
